// File: rtl/map_pkg.sv
// map_pkg: map geometry, cell-code palette constants and writer FSM states.
package map_pkg;
  localparam int GRID_W     = 8;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam logic [DATA_W-1:0] CELL_EMPTY  = 4'd0;
  localparam logic [DATA_W-1:0] CELL_CYAN   = 4'd1;
  localparam logic [DATA_W-1:0] CELL_MINT   = 4'd2;
  localparam logic [DATA_W-1:0] CELL_PURPLE = 4'd3;
  localparam logic [DATA_W-1:0] CELL_RED    = 4'd4;
  localparam logic [DATA_W-1:0] CELL_GREEN  = 4'd5;
  localparam logic [DATA_W-1:0] CELL_BLUE   = 4'd6;
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
endpackage

// File: rtl/mapa_cmd_fifo.sv
// mapa_cmd_fifo: small synchronous FIFO with flush, buffering {addr, data} cell commands.
module mapa_cmd_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign head    = mem[rp_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_comb begin
    wp_d  = flush ? '0 : wp_q + PW'(do_push);
    rp_d  = flush ? '0 : rp_q + PW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q] <= din;
  end
endmodule

// File: rtl/mapa_cell_writer.sv
// mapa_cell_writer: buffers cell-update commands and writes the map RAM, with a whole-map clear sweep.
module mapa_cell_writer #(
  parameter int DATA_W     = map_pkg::DATA_W,
  parameter int ADDR_W     = map_pkg::ADDR_W,
  parameter int GRID_W     = map_pkg::GRID_W,
  parameter int FIFO_DEPTH = map_pkg::FIFO_DEPTH,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            CmdValid,
  output logic                            CmdReady,
  input  logic [$clog2(GRID_W)-1:0]       CmdX,
  input  logic [$clog2(GRID_W)-1:0]       CmdY,
  input  logic [DATA_W-1:0]               CmdData,
  input  logic                            ClearReq,
  output logic                            Busy,
  output logic                            Done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] Pending,
  output logic [DATA_W-1:0]               MapaData,
  output logic [ADDR_W-1:0]               MapaAddr,
  output logic                            MapaWrite
);
  import map_pkg::*;
  localparam int EW = ADDR_W + DATA_W;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic wr_q, wr_d, done_q, done_d;
  logic idle, last, push, pop, flush, full, empty;
  logic [EW-1:0] din, head;
  assign idle  = state_q == S_IDLE;
  assign last  = cnt_q == '1;
  assign CmdReady = idle && !full && !ClearReq;
  assign push  = CmdValid && CmdReady;
  // A clear request wins over draining: the head is discarded rather than written.
  assign pop   = idle && !empty && !ClearReq;
  assign flush = idle && ClearReq;
  assign din   = {ADDR_W'(CmdY) * ADDR_W'(GRID_W) + ADDR_W'(CmdX), CmdData};
  mapa_cmd_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Clock), .rst(Reset), .push(push), .pop(pop), .flush(flush),
    .din(din), .head(head), .count(Pending), .full(full), .empty(empty)
  );
  always_comb begin
    state_d = idle ? (ClearReq ? S_CLEAR : S_IDLE) : (last ? S_IDLE : S_CLEAR);
    cnt_d   = idle ? '0 : cnt_q + ADDR_W'(1);
    wr_d    = idle ? pop : 1'b1;
    addr_d  = idle ? (pop ? head[EW-1:DATA_W] : addr_q) : cnt_q;
    data_d  = idle ? (pop ? head[DATA_W-1:0] : data_q) : CLEAR_VAL;
    done_d  = !idle && last;
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end
  assign MapaWrite = wr_q;
  assign MapaAddr  = addr_q;
  assign MapaData  = data_q;
  assign Done      = done_q;
  assign Busy      = !idle || Pending != '0 || wr_q;
endmodule

// File: tb/tb_mapa_cell_writer.sv
// tb_mapa_cell_writer: scenario tasks plus a queue-based reference model checked every cycle.
module tb_mapa_cell_writer;
  logic Clock = 1'b0, Reset = 1'b1;
  logic CmdValid = 1'b0, ClearReq = 1'b0;
  logic [2:0] CmdX = '0, CmdY = '0, Pending;
  logic [3:0] CmdData = '0, MapaData;
  logic [5:0] MapaAddr;
  logic CmdReady, Busy, Done, MapaWrite;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit chk = 1'b0;
  // reference model: command queue, sweep progress, expected registered outputs
  logic [9:0] m_q[$];
  bit m_clear = 1'b0;
  int m_idx = 0;
  logic m_wr = 1'b0, m_done = 1'b0;
  logic [5:0] m_addr = '0;
  logic [3:0] m_data = '0;
  typedef struct {int cyc; logic [5:0] a; logic [3:0] d; logic dn;} wr_t;
  wr_t wlog[$];

  mapa_cell_writer dut (
    .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdX(CmdX), .CmdY(CmdY), .CmdData(CmdData), .ClearReq(ClearReq),
    .Busy(Busy), .Done(Done), .Pending(Pending), .MapaData(MapaData),
    .MapaAddr(MapaAddr), .MapaWrite(MapaWrite)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin : monitor
    logic er, eb;
    if (!Reset) begin
      if (MapaWrite) wlog.push_back('{cyc, MapaAddr, MapaData, Done});
      if (chk) begin
        er = !m_clear && m_q.size() < 4 && !ClearReq;
        eb = m_clear || m_q.size() != 0 || m_wr;
        n_cmp++;
        if (CmdReady !== er) begin
          n_bad++;
          $display("FAIL ready: got %b want %b at cycle %0d", CmdReady, er, cyc);
        end
        n_cmp++;
        if ({MapaWrite, Done, MapaAddr, MapaData, Pending, Busy} !==
            {m_wr, m_done, m_addr, m_data, 3'(m_q.size()), eb}) begin
          n_bad++;
          $display("FAIL outputs: got wr=%b done=%b addr=%0d data=%0d pend=%0d busy=%b want wr=%b done=%b addr=%0d data=%0d pend=%0d busy=%b at cycle %0d",
                   MapaWrite, Done, MapaAddr, MapaData, Pending, Busy,
                   m_wr, m_done, m_addr, m_data, m_q.size(), eb, cyc);
        end
      end
    end
  end

  task automatic model_reset();
    m_q.delete();
    m_clear = 1'b0; m_idx = 0; m_wr = 1'b0; m_done = 1'b0; m_addr = '0; m_data = '0;
  endtask

  // drive one cycle of inputs, report CmdReady seen mid-cycle, advance the model at the edge
  task automatic step(input logic v, input logic [2:0] x, input logic [2:0] y,
                      input logic [3:0] d, input logic c, output logic rdy);
    logic [9:0] e;
    bit acc;
    CmdValid = v; CmdX = x; CmdY = y; CmdData = d; ClearReq = c;
    @(negedge Clock);
    rdy = CmdReady;
    @(posedge Clock);
    if (!Reset) begin
      if (m_clear) begin
        m_wr = 1'b1; m_addr = 6'(m_idx); m_data = 4'd0; m_done = (m_idx == 63);
        if (m_idx == 63) m_clear = 1'b0;
        m_idx++;
      end else begin
        acc = v && !c && m_q.size() < 4;
        m_done = 1'b0;
        if (c) begin
          m_q.delete(); m_clear = 1'b1; m_idx = 0; m_wr = 1'b0;
        end else if (m_q.size() > 0) begin
          e = m_q.pop_front(); m_wr = 1'b1; m_addr = e[9:4]; m_data = e[3:0];
        end else m_wr = 1'b0;
        if (acc) m_q.push_back({6'(int'(y) * 8 + int'(x)), d});
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    logic r;
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 3'd0, 4'd0, 1'b0, r);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({MapaWrite, Done, MapaAddr, MapaData, Pending, Busy} !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got wr=%b done=%b addr=%0d data=%0d pend=%0d busy=%b want all 0",
               MapaWrite, Done, MapaAddr, MapaData, Pending, Busy);
    end
    @(negedge Clock); Reset = 1'b0;
    @(posedge Clock); #1;
    model_reset();
    chk = 1'b1;
    n_cmp++;
    if (CmdReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", CmdReady); end
  endtask

  task automatic test_single();
    logic r;
    wlog.delete();
    step(1'b1, 3'd3, 3'd2, 4'd4, 1'b0, r);
    n_cmp++;
    if (r !== 1'b1) begin n_bad++; $display("FAIL single_accept: got %b want 1", r); end
    n_cmp++;
    if (MapaWrite !== 1'b0) begin n_bad++; $display("FAIL single_early: got wr=%b want 0", MapaWrite); end
    step(1'b0, 3'd0, 3'd0, 4'd0, 1'b0, r);
    n_cmp++;
    if ({MapaWrite, MapaAddr, MapaData} !== {1'b1, 6'd19, 4'd4}) begin
      n_bad++;
      $display("FAIL single_write: got wr=%b addr=%0d data=%0d want wr=1 addr=19 data=4", MapaWrite, MapaAddr, MapaData);
    end
    idle(3);
    n_cmp++;
    if (wlog.size() != 1 || Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_once: got writes=%0d busy=%b want writes=1 busy=0", wlog.size(), Busy);
    end
  endtask

  task automatic test_back_to_back();
    logic r;
    bit all_rdy = 1'b1, ok = 1'b1;
    wlog.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 3'(i), 3'd0, 4'(i + 1), 1'b0, r);
      all_rdy &= (r === 1'b1);
    end
    idle(3);
    n_cmp++;
    if (!all_rdy) begin n_bad++; $display("FAIL b2b_ready: got a dropped CmdReady want always 1"); end
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i].a !== 6'(i) || wlog[i].d !== 4'(i + 1) || wlog[i].cyc != wlog[0].cyc + i) ok = 1'b0;
    n_cmp++;
    if (wlog.size() != 6 || !ok) begin
      n_bad++;
      $display("FAIL b2b_writes: got %0d writes ordered=%b want 6 consecutive writes addr 0..5 data 1..6", wlog.size(), ok);
    end
  endtask

  task automatic test_clear_flush();
    logic r;
    bit ok = 1'b1;
    int dn = 0;
    wlog.delete();
    step(1'b1, 3'd5, 3'd5, 4'd3, 1'b0, r);
    step(1'b0, 3'd0, 3'd0, 4'd0, 1'b1, r);
    n_cmp++;
    if (r !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", r); end
    idle(70);
    for (int i = 0; i < wlog.size(); i++) begin
      if (wlog[i].a !== 6'(i) || wlog[i].d !== 4'd0 || wlog[i].cyc != wlog[0].cyc + i) ok = 1'b0;
      if (wlog[i].dn) dn++;
    end
    n_cmp++;
    if (wlog.size() != 64 || !ok) begin
      n_bad++;
      $display("FAIL sweep_writes: got %0d writes ordered=%b want 64 consecutive writes of 0 at 0..63", wlog.size(), ok);
    end
    n_cmp++;
    if (dn != 1 || wlog.size() != 64 || !wlog[63].dn) begin
      n_bad++;
      $display("FAIL sweep_done: got %0d done pulses want exactly 1 with address 63", dn);
    end
  endtask

  task automatic test_clear_priority();
    logic r;
    int k;
    wlog.delete();
    step(1'b1, 3'd1, 3'd1, 4'd5, 1'b1, r);
    n_cmp++;
    if (r !== 1'b0) begin n_bad++; $display("FAIL prio_ready: got %b want 0", r); end
    r = 1'b0;
    for (k = 0; k < 100 && !r; k++) step(1'b1, 3'd1, 3'd1, 4'd5, 1'b0, r);
    idle(3);
    n_cmp++;
    if (!r) begin n_bad++; $display("FAIL prio_timeout: got no acceptance in 100 cycles want acceptance"); end
    n_cmp++;
    if (wlog.size() != 65 || wlog[64].a !== 6'd9 || wlog[64].d !== 4'd5) begin
      n_bad++;
      $display("FAIL prio_after: got %0d writes want 65 ending with addr 9 data 5", wlog.size());
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic r;
    int k;
    step(1'b0, 3'd0, 3'd0, 4'd0, 1'b1, r);
    for (k = 0; k < 100 && !(m_wr && m_addr == 6'd30 && m_clear); k++) idle(1);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (MapaWrite !== 1'b0 || Done !== 1'b0 || k >= 100) begin
      n_bad++;
      $display("FAIL reset_async: got wr=%b done=%b want wr=0 done=0", MapaWrite, Done);
    end
    @(negedge Clock); Reset = 1'b0;
    @(posedge Clock); #1;
    wlog.delete();
    idle(10);
    n_cmp++;
    if (wlog.size() != 0 || Pending !== 3'd0 || CmdReady !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_quiet: got writes=%0d pend=%0d ready=%b want 0 0 1", wlog.size(), Pending, CmdReady);
    end
  endtask

  task automatic test_corner();
    logic r;
    wlog.delete();
    step(1'b1, 3'd7, 3'd7, 4'd6, 1'b0, r);
    step(1'b1, 3'd7, 3'd7, 4'd2, 1'b0, r);
    idle(3);
    n_cmp++;
    if (wlog.size() != 2 || wlog[0].a !== 6'd63 || wlog[0].d !== 4'd6 || wlog[1].a !== 6'd63 || wlog[1].d !== 4'd2) begin
      n_bad++;
      $display("FAIL corner: got %0d writes want addr 63 data 6 then addr 63 data 2", wlog.size());
    end
  endtask

  task automatic test_random();
    logic r;
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 4'($urandom),
           $urandom_range(0, 59) == 0, r);
    idle(70);
    n_cmp++;
    if (Pending !== 3'd0 || Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL random_drain: got pend=%0d busy=%b want 0 0", Pending, Busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clear_flush();
    test_clear_priority();
    test_reset_mid_sweep();
    test_corner();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
